// File: rtl/io_block_queue_if.sv
// Host command, SSD sub-request and completion bundle for io_block_queue.
// The queue itself attaches through the slave modport; the host/SSD side uses master.
interface io_block_queue_if #(
    parameter int LBA_W  = 64,
    parameter int LEN_W  = 32,
    parameter int DATA_W = 64
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [7:0]        cmd_opcode;
    logic [LBA_W-1:0]  cmd_lba;
    logic [LEN_W-1:0]  cmd_length;
    logic [DATA_W-1:0] cmd_data;

    logic              ssd_cmd_valid;
    logic              ssd_cmd_ready;
    logic [7:0]        ssd_opcode;
    logic [LBA_W-1:0]  ssd_lba;
    logic [LEN_W-1:0]  ssd_length;
    logic [DATA_W-1:0] ssd_data;
    logic              ssd_last;
    logic              ssd_done;

    logic              cpl_valid;
    logic              cpl_ready;
    logic [7:0]        cpl_id;
    logic [LEN_W-1:0]  cpl_bytes;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_lba, cmd_length, cmd_data,
        input  ssd_cmd_ready, ssd_done, cpl_ready,
        output cmd_ready,
        output ssd_cmd_valid, ssd_opcode, ssd_lba, ssd_length, ssd_data, ssd_last,
        output cpl_valid, cpl_id, cpl_bytes
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_lba, cmd_length, cmd_data,
        output ssd_cmd_ready, ssd_done, cpl_ready,
        input  cmd_ready,
        input  ssd_cmd_valid, ssd_opcode, ssd_lba, ssd_length, ssd_data, ssd_last,
        input  cpl_valid, cpl_id, cpl_bytes
    );
endinterface

// File: rtl/io_block_queue.sv
// Host command FIFO that splits each command into SSD sub-requests which never
// cross a BLOCK_BYTES boundary, limits in-flight sub-requests and returns in-order completions.
module io_block_queue #(
    parameter int DEPTH       = 8,
    parameter int BLOCK_BYTES = 4096,
    parameter int MAX_OUT     = 4,
    parameter int LBA_W       = 64,
    parameter int LEN_W       = 32,
    parameter int DATA_W      = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    io_block_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [31:0]            cmds_completed,
    output logic                   proto_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, CPL} state_t;
    state_t state_reg, state_next;

    logic [7:0]        mem_opcode [DEPTH];
    logic [LBA_W-1:0]  mem_lba    [DEPTH];
    logic [LEN_W-1:0]  mem_length [DEPTH];
    logic [DATA_W-1:0] mem_data   [DEPTH];
    logic [7:0]        mem_id     [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [7:0]        seq_reg;
    logic [LBA_W-1:0]  cur_lba_reg;
    logic [LEN_W-1:0]  remaining_reg, orig_len_reg;
    logic [7:0]        opcode_reg, id_reg;
    logic [DATA_W-1:0] data_reg;
    logic [3:0]        outstanding_reg;
    logic              cpl_valid_reg, proto_err_reg;
    logic [31:0]       cmds_completed_reg;

    logic              push, pop, issue, cpl_fire;
    logic [LBA_W-1:0]  blk_off;
    logic [LEN_W-1:0]  blk_space, chunk;

    assign bus.cmd_ready = (count_reg < CNT_W'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state_reg == IDLE) && (count_reg != '0);

    // Bytes left before the next block boundary bound the size of the current chunk.
    assign blk_off   = cur_lba_reg & LBA_W'(BLOCK_BYTES - 1);
    assign blk_space = LEN_W'(BLOCK_BYTES) - LEN_W'(blk_off);
    assign chunk     = (remaining_reg < blk_space) ? remaining_reg : blk_space;

    assign bus.ssd_cmd_valid = (state_reg == ISSUE) && (outstanding_reg < 4'(MAX_OUT));
    assign bus.ssd_length    = (state_reg == ISSUE) ? chunk : '0;
    assign bus.ssd_last      = (state_reg == ISSUE) && (chunk == remaining_reg);
    assign bus.ssd_opcode    = opcode_reg;
    assign bus.ssd_lba       = cur_lba_reg;
    assign bus.ssd_data      = data_reg;
    assign bus.cpl_valid     = cpl_valid_reg;
    assign bus.cpl_id        = id_reg;
    assign bus.cpl_bytes     = orig_len_reg;
    assign fifo_count        = count_reg;
    assign cmds_completed    = cmds_completed_reg;
    assign proto_err         = proto_err_reg;

    assign issue    = bus.ssd_cmd_valid && bus.ssd_cmd_ready;
    assign cpl_fire = cpl_valid_reg && bus.cpl_ready;

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_opcode[wr_ptr_reg] <= bus.cmd_opcode;
            mem_lba[wr_ptr_reg]    <= bus.cmd_lba;
            mem_length[wr_ptr_reg] <= bus.cmd_length;
            mem_data[wr_ptr_reg]   <= bus.cmd_data;
            mem_id[wr_ptr_reg]     <= seq_reg;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pop) state_next = (mem_length[rd_ptr_reg] == '0) ? CPL : ISSUE;
            ISSUE:   if (issue && bus.ssd_last) state_next = DRAIN;
            DRAIN:   if ((outstanding_reg == 4'd0) || ((outstanding_reg == 4'd1) && bus.ssd_done))
                         state_next = CPL;
            CPL:     if (bus.cpl_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= IDLE;
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            count_reg          <= '0;
            seq_reg            <= '0;
            cur_lba_reg        <= '0;
            remaining_reg      <= '0;
            orig_len_reg       <= '0;
            opcode_reg         <= '0;
            id_reg             <= '0;
            data_reg           <= '0;
            outstanding_reg    <= '0;
            cpl_valid_reg      <= 1'b0;
            proto_err_reg      <= 1'b0;
            cmds_completed_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cpl_valid_reg <= (state_next == CPL);

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                seq_reg    <= seq_reg + 8'd1;
            end

            if (pop) begin
                rd_ptr_reg    <= rd_ptr_reg + PTR_W'(1);
                cur_lba_reg   <= mem_lba[rd_ptr_reg];
                remaining_reg <= mem_length[rd_ptr_reg];
                orig_len_reg  <= mem_length[rd_ptr_reg];
                opcode_reg    <= mem_opcode[rd_ptr_reg];
                data_reg      <= mem_data[rd_ptr_reg];
                id_reg        <= mem_id[rd_ptr_reg];
            end else if (issue) begin
                cur_lba_reg   <= cur_lba_reg + LBA_W'(chunk);
                remaining_reg <= remaining_reg - chunk;
            end

            if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
            else if (pop && !push) count_reg <= count_reg - CNT_W'(1);

            // A done with nothing in flight is a protocol violation; the counter saturates at 0.
            if (issue && !bus.ssd_done)                          outstanding_reg <= outstanding_reg + 4'd1;
            else if (!issue && bus.ssd_done && outstanding_reg != 4'd0) outstanding_reg <= outstanding_reg - 4'd1;

            if (bus.ssd_done && (outstanding_reg == 4'd0)) proto_err_reg <= 1'b1;

            if (cpl_fire) cmds_completed_reg <= cmds_completed_reg + 32'd1;
        end
    end
endmodule

// File: tb/tb_io_block_queue.sv
// Directed bench for io_block_queue: scoreboard of expected sub-requests and completions,
// with a simple SSD model that answers each issue with a delayed done pulse.
module tb_io_block_queue;
    localparam int DEPTH       = 8;
    localparam int BLOCK_BYTES = 4096;
    localparam int MAX_OUT     = 2;
    localparam int LBA_W       = 64;
    localparam int LEN_W       = 32;
    localparam int DATA_W      = 64;
    localparam int DONE_DLY    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  fifo_count;
    logic [31:0] cmds_completed;
    logic        proto_err;

    always #5 clk = ~clk;

    io_block_queue_if #(.LBA_W(LBA_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

    io_block_queue #(
        .DEPTH(DEPTH), .BLOCK_BYTES(BLOCK_BYTES), .MAX_OUT(MAX_OUT),
        .LBA_W(LBA_W), .LEN_W(LEN_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .fifo_count(fifo_count), .cmds_completed(cmds_completed), .proto_err(proto_err)
    );

    typedef struct {
        logic [63:0] lba;
        logic [31:0] len;
        logic        last;
        logic [7:0]  op;
        logic [63:0] data;
    } sub_t;
    typedef struct {
        logic [7:0]  id;
        logic [31:0] bytes;
    } cpl_t;

    sub_t        exp_sub[$];
    cpl_t        exp_cpl[$];
    int          done_tmr[$];
    int          checks = 0;
    int          errors = 0;
    int          iss_total = 0;
    logic [7:0]  seq_model = 8'd0;
    bit          done_hold = 0;
    bit          done_kick = 0;
    bit          last_cmd_acc = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference split: walk the command, cutting at every block boundary.
    task automatic model_push(logic [7:0] op, logic [63:0] lba, logic [31:0] len, logic [63:0] data);
        cpl_t        c;
        sub_t        s;
        logic [63:0] a;
        logic [31:0] rem, space, ch;
        c.id = seq_model;
        c.bytes = len;
        exp_cpl.push_back(c);
        seq_model = seq_model + 8'd1;
        a = lba;
        rem = len;
        while (rem != 0) begin
            space = BLOCK_BYTES - 32'(a % BLOCK_BYTES);
            ch = (rem < space) ? rem : space;
            s.lba = a; s.len = ch; s.last = (ch == rem); s.op = op; s.data = data;
            exp_sub.push_back(s);
            a = a + 64'(ch);
            rem = rem - ch;
        end
    endtask

    // One clock: sample handshakes before the edge, score them after it, then drive the SSD done line.
    task automatic step();
        bit          cmd_acc, iss, cpl;
        logic [7:0]  c_op, s_op, c_id;
        logic [63:0] c_lba, c_data, s_lba, s_data;
        logic [31:0] c_len, s_len, c_bytes;
        logic        s_last;
        sub_t        es;
        cpl_t        ec;
        @(negedge clk);
        cmd_acc = !rst && bus.cmd_valid && bus.cmd_ready;
        iss     = !rst && bus.ssd_cmd_valid && bus.ssd_cmd_ready;
        cpl     = !rst && bus.cpl_valid && bus.cpl_ready;
        c_op = bus.cmd_opcode; c_lba = bus.cmd_lba; c_len = bus.cmd_length; c_data = bus.cmd_data;
        s_op = bus.ssd_opcode; s_lba = bus.ssd_lba; s_len = bus.ssd_length; s_data = bus.ssd_data;
        s_last = bus.ssd_last; c_id = bus.cpl_id; c_bytes = bus.cpl_bytes;
        @(posedge clk);
        #1;
        last_cmd_acc = cmd_acc;
        if (cmd_acc) begin
            $display("cmd  op=%0h lba=%0d len=%0d", c_op, c_lba, c_len);
            model_push(c_op, c_lba, c_len, c_data);
        end
        if (iss) begin
            iss_total++;
            $display("sub  lba=%0d len=%0d last=%0b", s_lba, s_len, s_last);
            chk("sub_expected", 64'(exp_sub.size() > 0), 64'd1);
            if (exp_sub.size() > 0) begin
                es = exp_sub.pop_front();
                chk("sub_lba", s_lba, es.lba);
                chk("sub_len", 64'(s_len), 64'(es.len));
                chk("sub_last", 64'(s_last), 64'(es.last));
                chk("sub_op", 64'(s_op), 64'(es.op));
                chk("sub_data", s_data, es.data);
            end
        end
        if (cpl) begin
            $display("cpl  id=%0d bytes=%0d", c_id, c_bytes);
            chk("cpl_expected", 64'(exp_cpl.size() > 0), 64'd1);
            if (exp_cpl.size() > 0) begin
                ec = exp_cpl.pop_front();
                chk("cpl_id", 64'(c_id), 64'(ec.id));
                chk("cpl_bytes", 64'(c_bytes), 64'(ec.bytes));
            end
        end
        bus.ssd_done = 1'b0;
        if (!done_hold) begin
            foreach (done_tmr[i]) if (done_tmr[i] > 0) done_tmr[i]--;
            if (done_tmr.size() > 0 && done_tmr[0] == 0) begin
                void'(done_tmr.pop_front());
                bus.ssd_done = 1'b1;
            end
        end else if (done_kick) begin
            if (done_tmr.size() > 0) void'(done_tmr.pop_front());
            bus.ssd_done = 1'b1;
            done_kick = 0;
        end
        if (iss) done_tmr.push_back(DONE_DLY);
    endtask

    task automatic push_cmd(logic [7:0] op, logic [63:0] lba, logic [31:0] len, logic [63:0] data);
        bit acc = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_opcode = op; bus.cmd_lba = lba; bus.cmd_length = len; bus.cmd_data = data;
        for (int i = 0; i < 200 && !acc; i++) begin
            step();
            acc = last_cmd_acc;
        end
        chk("push_accepted", 64'(acc), 64'd1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp_sub.size() == 0 && exp_cpl.size() == 0 && done_tmr.size() == 0) break;
            step();
        end
        chk({tag, "_sub_left"}, 64'(exp_sub.size()), 64'd0);
        chk({tag, "_cpl_left"}, 64'(exp_cpl.size()), 64'd0);
    endtask

    task automatic check_reset(string p);
        chk({p, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        chk({p, "_ssd_cmd_valid"}, 64'(bus.ssd_cmd_valid), 64'd0);
        chk({p, "_ssd_last"}, 64'(bus.ssd_last), 64'd0);
        chk({p, "_cpl_valid"}, 64'(bus.cpl_valid), 64'd0);
        chk({p, "_ssd_opcode"}, 64'(bus.ssd_opcode), 64'd0);
        chk({p, "_ssd_lba"}, bus.ssd_lba, 64'd0);
        chk({p, "_ssd_length"}, 64'(bus.ssd_length), 64'd0);
        chk({p, "_ssd_data"}, bus.ssd_data, 64'd0);
        chk({p, "_cpl_id"}, 64'(bus.cpl_id), 64'd0);
        chk({p, "_cpl_bytes"}, 64'(bus.cpl_bytes), 64'd0);
        chk({p, "_fifo_count"}, 64'(fifo_count), 64'd0);
        chk({p, "_cmds_completed"}, 64'(cmds_completed), 64'd0);
        chk({p, "_proto_err"}, 64'(proto_err), 64'd0);
    endtask

    // Reset is raised mid-cycle so its asynchronous effect is visible before any clock edge.
    task automatic do_reset(string p);
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.ssd_done = 1'b0;
        #1;
        check_reset(p);
        exp_sub.delete();
        exp_cpl.delete();
        done_tmr.delete();
        seq_model = 8'd0;
        done_hold = 0;
        done_kick = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int  iss_mark;
        bit  any_acc;
        bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_lba = '0; bus.cmd_length = '0; bus.cmd_data = '0;
        bus.ssd_cmd_ready = 1'b1; bus.ssd_done = 1'b0; bus.cpl_ready = 1'b1;
        #2;
        do_reset("rst0");

        // Aligned split plus pop-to-issue latency.
        push_cmd(8'h11, 64'd0, 32'd10000, 64'hDEAD_BEEF_0000_0001);
        chk("lat_after_push_valid", 64'(bus.ssd_cmd_valid), 64'd0);
        step();
        chk("lat_after_pop_valid", 64'(bus.ssd_cmd_valid), 64'd1);
        wait_drain("aligned");
        chk("aligned_completed", 64'(cmds_completed), 64'd1);

        // Unaligned split across a single boundary.
        push_cmd(8'h22, 64'd4000, 32'd200, 64'h0123_4567_89AB_CDEF);
        wait_drain("unaligned");
        chk("unaligned_completed", 64'(cmds_completed), 64'd2);

        // Zero-length command: completion without SSD traffic.
        do_reset("rst1");
        iss_mark = iss_total;
        push_cmd(8'h33, 64'd512, 32'd0, 64'd7);
        chk("zl_cpl_early", 64'(bus.cpl_valid), 64'd0);
        step();
        chk("zl_cpl_valid", 64'(bus.cpl_valid), 64'd1);
        wait_drain("zl");
        chk("zl_no_ssd", 64'(iss_total - iss_mark), 64'd0);

        // In-flight limit with done pulses withheld.
        done_hold = 1;
        iss_mark = iss_total;
        push_cmd(8'h44, 64'd0, 32'd16384, 64'd44);
        repeat (10) step();
        chk("maxout_issues", 64'(iss_total - iss_mark), 64'd2);
        chk("maxout_valid_low", 64'(bus.ssd_cmd_valid), 64'd0);
        done_kick = 1;
        step();
        chk("maxout_still_low", 64'(bus.ssd_cmd_valid), 64'd0);
        step();
        chk("maxout_valid_after_done", 64'(bus.ssd_cmd_valid), 64'd1);
        step();
        chk("maxout_third_issue", 64'(iss_total - iss_mark), 64'd3);
        done_hold = 0;
        wait_drain("maxout");

        // FIFO fill with completions held off.
        do_reset("rst2");
        bus.cpl_ready = 1'b0;
        for (int i = 0; i < 9; i++) push_cmd(8'h50, 64'd0, 32'd0, 64'(i));
        chk("fill_count", 64'(fifo_count), 64'd8);
        chk("fill_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        bus.cmd_valid = 1'b1; bus.cmd_opcode = 8'h50; bus.cmd_lba = '0; bus.cmd_length = '0; bus.cmd_data = 64'd9;
        any_acc = 0;
        repeat (5) begin
            step();
            any_acc |= last_cmd_acc;
        end
        chk("fill_tenth_blocked", 64'(any_acc), 64'd0);
        bus.cpl_ready = 1'b1;
        push_cmd(8'h50, 64'd0, 32'd0, 64'd9);
        wait_drain("fill");
        chk("fill_completed", 64'(cmds_completed), 64'd10);

        // Protocol error while idle, then reset in the middle of issuing.
        do_reset("rst3");
        done_hold = 1;
        done_kick = 1;
        step();
        step();
        chk("proto_err_set", 64'(proto_err), 64'd1);
        done_hold = 0;
        bus.ssd_cmd_ready = 1'b0;
        push_cmd(8'h66, 64'd0, 32'd8192, 64'd66);
        step();
        step();
        chk("mid_issue_valid", 64'(bus.ssd_cmd_valid), 64'd1);
        chk("mid_issue_len", 64'(bus.ssd_length), 64'd4096);
        do_reset("rst4");
        bus.ssd_cmd_ready = 1'b1;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
